// File: rtl/oa222_stim_sequencer.sv
// ----------------------------------------------------------------------------
// oa222_stim_sequencer
//
// Stimulus sequencer and checker for the six-input OR-AND-OR-AND cell
// Q = (IN1|IN2) & (IN3|IN4) & (IN5|IN6), used in power characterisation runs.
// A sweep drives up to 64 vectors onto the cell. After each vector is applied
// the block waits a settle interval, then samples the cell output. It checks
// the sample against the golden function and counts mismatches and output
// toggles.
//
// Optional feature: define OA222_STIM_LFSR_EN to enable MODE=2'b10, a 6-bit
// Fibonacci LFSR sweep (x^6 + x^5 + 1, seed 6'h01). Without the macro, MODE=2'b10
// runs a binary sweep and no LFSR state is built.
//
// Parameters:
//   SETTLE_CYC  wait cycles after each stimulus update (0..255)
//   CNT_W       width of the mismatch and toggle counters
//
// Ports:
//   CLK      in   clock, rising edge
//   RSTB     in   asynchronous active-low reset
//   START    in   begin a sweep (only honoured in IDLE)
//   ABORT    in   synchronous abort, overrides everything but RSTB
//   MODE     in   sweep order: 00 binary, 01 Gray, 10 LFSR/binary, 11 binary
//   NUM_VEC  in   vectors per sweep (0..64, larger values clamp to 64)
//   STIM     out  cell inputs, bit0 = IN1 ... bit5 = IN6
//   DUT_Q    in   cell output, only looked at in SAMPLE
//   BUSY     out  high whenever not IDLE
//   DONE     out  one-cycle pulse on normal sweep completion
//   ERR_CNT  out  saturating mismatch count
//   TOG_CNT  out  saturating count of sampled Q transitions
//   ERR_VEC  out  STIM value at the first mismatch
//   ERR_VLD  out  ERR_VEC holds a valid first-mismatch value
// ----------------------------------------------------------------------------
module oa222_stim_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       MODE,
  input  logic [6:0]       NUM_VEC,
  output logic [5:0]       STIM,
  input  logic             DUT_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] TOG_CNT,
  output logic [5:0]       ERR_VEC,
  output logic             ERR_VLD
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_SAMPLE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

`ifdef OA222_STIM_LFSR_EN
  localparam logic [5:0] LFSR_SEED = 6'h01;
`endif

  // Golden cell function.
  function automatic logic golden_q(input logic [5:0] v);
    return (v[0] | v[1]) & (v[2] | v[3]) & (v[4] | v[5]);
  endfunction

  // Vector for sweep position n in the index-derived orders (binary, Gray).
  function automatic logic [5:0] order_vec(input logic [1:0] mode, input logic [5:0] n);
    logic [5:0] v;
    case (mode)
      2'b01:   v = n ^ (n >> 1);
      default: v = n;
    endcase
    return v;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c == {CNT_W{1'b1}}) begin
      r = c;
    end else begin
      r = c + CNT_W'(1);
    end
    return r;
  endfunction

`ifdef OA222_STIM_LFSR_EN
  // One Fibonacci step: taps at stages 6 and 5, shifting toward the MSB.
  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[4]};
  endfunction
`endif

  state_t           state_r,   state_nxt;
  logic [5:0]       idx_r,     idx_nxt;
  logic [6:0]       num_vec_r, num_vec_nxt;
  logic [1:0]       mode_r,    mode_nxt;
  logic [7:0]       settle_r,  settle_nxt;
  logic [5:0]       stim_r,    stim_nxt;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt;
  logic [CNT_W-1:0] tog_cnt_r, tog_cnt_nxt;
  logic [5:0]       err_vec_r, err_vec_nxt;
  logic             err_vld_r, err_vld_nxt;
  logic             prev_q_r,  prev_q_nxt;
  logic             first_r,   first_nxt;
  logic             busy_r;
  logic             done_r;
`ifdef OA222_STIM_LFSR_EN
  logic [5:0]       lfsr_r,    lfsr_nxt;
`endif

  logic [6:0]       nv_clamped_s;
  logic [5:0]       idx_inc_s;
  logic             last_vec_s;

  // Sweep length clamp, next index and last-vector detect.
  always_comb begin
    if (NUM_VEC > 7'd64) begin
      nv_clamped_s = 7'd64;
    end else begin
      nv_clamped_s = NUM_VEC;
    end
    idx_inc_s  = idx_r + 6'd1;
    last_vec_s = ({1'b0, idx_r} == (num_vec_r - 7'd1));
  end

  // Next-state and next-register logic for the sweep FSM.
  always_comb begin
    state_nxt   = state_r;
    idx_nxt     = idx_r;
    num_vec_nxt = num_vec_r;
    mode_nxt    = mode_r;
    settle_nxt  = settle_r;
    stim_nxt    = stim_r;
    err_cnt_nxt = err_cnt_r;
    tog_cnt_nxt = tog_cnt_r;
    err_vec_nxt = err_vec_r;
    err_vld_nxt = err_vld_r;
    prev_q_nxt  = prev_q_r;
    first_nxt   = first_r;
`ifdef OA222_STIM_LFSR_EN
    lfsr_nxt    = lfsr_r;
`endif

    if (ABORT && (state_r != ST_IDLE)) begin
      // Abort keeps the statistics and starts the next sweep with fresh toggle history.
      state_nxt = ST_IDLE;
      stim_nxt  = 6'd0;
      first_nxt = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START && !ABORT) begin
            err_cnt_nxt = {CNT_W{1'b0}};
            tog_cnt_nxt = {CNT_W{1'b0}};
            err_vec_nxt = 6'd0;
            err_vld_nxt = 1'b0;
            if (nv_clamped_s == 7'd0) begin
              state_nxt = ST_DONE;
            end else begin
              mode_nxt    = MODE;
              num_vec_nxt = nv_clamped_s;
              idx_nxt     = 6'd0;
              settle_nxt  = SETTLE_LD;
              state_nxt   = ST_SETTLE;
`ifdef OA222_STIM_LFSR_EN
              lfsr_nxt = LFSR_SEED;
              if (MODE == 2'b10) begin
                stim_nxt = LFSR_SEED;
              end else begin
                stim_nxt = order_vec(MODE, 6'd0);
              end
`else
              stim_nxt = order_vec(MODE, 6'd0);
`endif
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end

        ST_SETTLE: begin
          if (settle_r == 8'd0) begin
            state_nxt = ST_SAMPLE;
          end else begin
            settle_nxt = settle_r - 8'd1;
          end
        end

        ST_SAMPLE: begin
          if (DUT_Q != golden_q(stim_r)) begin
            err_cnt_nxt = sat_inc(err_cnt_r);
            if (!err_vld_r) begin
              err_vec_nxt = stim_r;
              err_vld_nxt = 1'b1;
            end else begin
              err_vec_nxt = err_vec_r;
            end
          end else begin
            err_cnt_nxt = err_cnt_r;
          end

          // The first sample of a sweep has no predecessor to toggle from.
          if (!first_r && (DUT_Q != prev_q_r)) begin
            tog_cnt_nxt = sat_inc(tog_cnt_r);
          end else begin
            tog_cnt_nxt = tog_cnt_r;
          end
          prev_q_nxt = DUT_Q;
          first_nxt  = 1'b0;

          if (last_vec_s) begin
            stim_nxt  = 6'd0;
            state_nxt = ST_DONE;
          end else begin
            idx_nxt    = idx_inc_s;
            settle_nxt = SETTLE_LD;
            state_nxt  = ST_SETTLE;
`ifdef OA222_STIM_LFSR_EN
            lfsr_nxt = lfsr_step(lfsr_r);
            if (mode_r == 2'b10) begin
              stim_nxt = lfsr_step(lfsr_r);
            end else begin
              stim_nxt = order_vec(mode_r, idx_inc_s);
            end
`else
            stim_nxt = order_vec(mode_r, idx_inc_s);
`endif
          end
        end

        ST_DONE: begin
          state_nxt = ST_IDLE;
          first_nxt = 1'b1;
        end

        default: begin
          state_nxt = ST_IDLE;
          stim_nxt  = 6'd0;
        end
      endcase
    end
  end

  // State and output registers; BUSY and DONE are registered from the next state.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_r   <= ST_IDLE;
      idx_r     <= 6'd0;
      num_vec_r <= 7'd0;
      mode_r    <= 2'b00;
      settle_r  <= 8'd0;
      stim_r    <= 6'd0;
      err_cnt_r <= {CNT_W{1'b0}};
      tog_cnt_r <= {CNT_W{1'b0}};
      err_vec_r <= 6'd0;
      err_vld_r <= 1'b0;
      prev_q_r  <= 1'b0;
      first_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef OA222_STIM_LFSR_EN
      lfsr_r    <= 6'd0;
`endif
    end else begin
      state_r   <= state_nxt;
      idx_r     <= idx_nxt;
      num_vec_r <= num_vec_nxt;
      mode_r    <= mode_nxt;
      settle_r  <= settle_nxt;
      stim_r    <= stim_nxt;
      err_cnt_r <= err_cnt_nxt;
      tog_cnt_r <= tog_cnt_nxt;
      err_vec_r <= err_vec_nxt;
      err_vld_r <= err_vld_nxt;
      prev_q_r  <= prev_q_nxt;
      first_r   <= first_nxt;
      busy_r    <= (state_nxt != ST_IDLE);
      done_r    <= (state_nxt == ST_DONE);
`ifdef OA222_STIM_LFSR_EN
      lfsr_r    <= lfsr_nxt;
`endif
    end
  end

  assign STIM    = stim_r;
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign ERR_CNT = err_cnt_r;
  assign TOG_CNT = tog_cnt_r;
  assign ERR_VEC = err_vec_r;
  assign ERR_VLD = err_vld_r;

endmodule

// File: tb/tb_oa222_stim_sequencer.sv
// ----------------------------------------------------------------------------
// tb_oa222_stim_sequencer
//
// Drives directed sweeps into oa222_stim_sequencer with a behavioural cell
// model on DUT_Q. Expected outputs come from a timing/arithmetic model of the
// sweep: vector i is applied from k = i*P to (i+1)*P - 1 cycles after the
// START-accept edge and is sampled on edge (i+1)*P, where P = SETTLE_CYC + 2.
// ----------------------------------------------------------------------------
module tb_oa222_stim_sequencer;

  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 2;

  logic       CLK = 1'b0;
  logic       RSTB;
  logic       START;
  logic       ABORT;
  logic [1:0] MODE;
  logic [6:0] NUM_VEC;
  logic [5:0] STIM;
  logic       DUT_Q;
  logic       BUSY;
  logic       DONE;
  logic [7:0] ERR_CNT;
  logic [7:0] TOG_CNT;
  logic [5:0] ERR_VEC;
  logic       ERR_VLD;

  int n_cmp = 0;
  int n_bad = 0;

  int dut_kind = 0;   // 0 correct cell, 1 stuck-at-1, 2 inverted on vectors 5 and 9
  int m_mode   = 0;
  int m_n      = 0;
  int m_abort  = 0;
  int done_k   = -1;
  logic [5:0] seen_stim [64];
  logic [5:0] gray_exp [8] = '{6'h00, 6'h01, 6'h03, 6'h02, 6'h06, 6'h07, 6'h05, 6'h04};

  always #5 CLK = ~CLK;

  oa222_stim_sequencer #(
    .SETTLE_CYC(SETTLE),
    .CNT_W     (8)
  ) dut (
    .CLK    (CLK),
    .RSTB   (RSTB),
    .START  (START),
    .ABORT  (ABORT),
    .MODE   (MODE),
    .NUM_VEC(NUM_VEC),
    .STIM   (STIM),
    .DUT_Q  (DUT_Q),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR_CNT(ERR_CNT),
    .TOG_CNT(TOG_CNT),
    .ERR_VEC(ERR_VEC),
    .ERR_VLD(ERR_VLD)
  );

  function automatic bit gold(input int v);
    return ((v & 3) != 0) && ((v & 12) != 0) && ((v & 48) != 0);
  endfunction

  function automatic bit dut_resp(input int kind, input int v);
    bit r;
    case (kind)
      1:       r = 1'b1;
      2:       r = (v == 5 || v == 9) ? !gold(v) : gold(v);
      default: r = gold(v);
    endcase
    return r;
  endfunction

  function automatic int mvec(input int mode, input int i);
    if (mode == 1) return (i ^ (i >> 1)) & 63;
`ifdef OA222_STIM_LFSR_EN
    if (mode == 2) begin
      int s;
      s = 1;
      for (int j = 0; j < i; j++) s = ((s << 1) & 62) | (((s >> 5) ^ (s >> 4)) & 1);
      return s;
    end
`endif
    return i & 63;
  endfunction

  assign DUT_Q = dut_resp(dut_kind, int'(STIM));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs k cycles after the START-accept edge.
  task automatic model_check(input int k);
    int dv, e_stim, e_busy, e_done, e_err, e_tog, e_ev, e_vld;
    bit q, pq;
    if (m_abort > 0 && k >= m_abort) begin
      e_busy = 0; e_done = 0; e_stim = 0; dv = (m_abort - 1) / P;
    end else if (k < m_n * P) begin
      e_busy = 1; e_done = 0; e_stim = mvec(m_mode, k / P); dv = k / P;
    end else if (k == m_n * P) begin
      e_busy = 1; e_done = 1; e_stim = 0; dv = m_n;
    end else begin
      e_busy = 0; e_done = 0; e_stim = 0; dv = m_n;
    end
    e_err = 0; e_tog = 0; e_ev = 0; e_vld = 0; pq = 1'b0;
    for (int i = 0; i < dv; i++) begin
      q = dut_resp(dut_kind, mvec(m_mode, i));
      if (q != gold(mvec(m_mode, i))) begin
        e_err = (e_err < 255) ? e_err + 1 : 255;
        if (e_vld == 0) begin
          e_ev  = mvec(m_mode, i);
          e_vld = 1;
        end
      end
      if (i > 0 && q != pq) e_tog = (e_tog < 255) ? e_tog + 1 : 255;
      pq = q;
    end
    chk($sformatf("stim@k%0d", k), STIM, e_stim);
    chk($sformatf("busy@k%0d", k), BUSY, e_busy);
    chk($sformatf("done@k%0d", k), DONE, e_done);
    chk($sformatf("err_cnt@k%0d", k), ERR_CNT, e_err);
    chk($sformatf("tog_cnt@k%0d", k), TOG_CNT, e_tog);
    chk($sformatf("err_vec@k%0d", k), ERR_VEC, e_ev);
    chk($sformatf("err_vld@k%0d", k), ERR_VLD, e_vld);
    if (k < m_n * P && (k % P) == 0) seen_stim[k / P] = STIM;
    if (DONE === 1'b1 && done_k < 0) done_k = k;
  endtask

  // One sweep: START for one edge, then compare every cycle until IDLE.
  task automatic run_sweep(input int mode, input int nv, input int kind,
                           input int abort_k, input int busy_start_k);
    int last;
    @(negedge CLK);
    dut_kind = kind;
    MODE     = mode[1:0];
    NUM_VEC  = nv[6:0];
    START    = 1'b1;
    m_mode   = mode;
    m_n      = (nv > 64) ? 64 : nv;
    m_abort  = abort_k;
    done_k   = -1;
    @(negedge CLK);
    START   = 1'b0;
    MODE    = ~MODE;
    NUM_VEC = 7'd3;
    last = (abort_k > 0) ? abort_k + 1 : m_n * P + 1;
    for (int k = 0; k <= last; k++) begin
      model_check(k);
      ABORT = (abort_k > 0 && k + 1 == abort_k);
      START = (busy_start_k > 0 && k + 1 == busy_start_k);
      @(negedge CLK);
    end
    ABORT = 1'b0;
    START = 1'b0;
  endtask

  initial begin
    RSTB = 1'b0; START = 1'b0; ABORT = 1'b0; MODE = 2'b00; NUM_VEC = 7'd0;
    repeat (2) @(negedge CLK);
    chk("rst_stim", STIM, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err_cnt", ERR_CNT, 0);
    chk("rst_tog_cnt", TOG_CNT, 0);
    chk("rst_err_vld", ERR_VLD, 0);
    RSTB = 1'b1;
    @(negedge CLK);

    // Binary sweep, correct cell: 9 of the 16 upper-bit blocks have Q=0111, giving 9 rises and 8 falls.
    run_sweep(0, 64, 0, 0, 0);
    chk("bin_done_cycle", done_k, 256);
    chk("bin_err_cnt", ERR_CNT, 0);
    chk("bin_tog_cnt", TOG_CNT, 17);

    // Stuck-at-1 cell: 37 vectors have golden Q=0.
    run_sweep(0, 64, 1, 0, 0);
    chk("stuck_err_cnt", ERR_CNT, 37);
    chk("stuck_err_vec", ERR_VEC, 6'h00);
    chk("stuck_err_vld", ERR_VLD, 1);
    chk("stuck_tog_cnt", TOG_CNT, 0);

    // Gray order, 8 vectors.
    run_sweep(1, 8, 0, 0, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("gray_vec%0d", i), seen_stim[i], gray_exp[i]);
    chk("gray_done_cycle", done_k, 32);
    chk("gray_err_cnt", ERR_CNT, 0);

    // Cell wrong only on vectors 5 and 9.
    run_sweep(0, 12, 2, 0, 0);
    chk("flip_err_cnt", ERR_CNT, 2);
    chk("flip_err_vec", ERR_VEC, 6'h05);
    chk("flip_err_vld", ERR_VLD, 1);
    chk("flip_tog_cnt", TOG_CNT, 4);

    // Zero-length sweep clears the previous results.
    run_sweep(0, 0, 1, 0, 0);
    chk("nv0_done_cycle", done_k, 0);
    chk("nv0_err_cnt", ERR_CNT, 0);
    chk("nv0_err_vld", ERR_VLD, 0);

    // Abort at k=10 with a stuck cell, plus a START pulse while busy.
    run_sweep(0, 64, 1, 10, 3);
    chk("abort_no_done", done_k, -1);
    chk("abort_err_cnt", ERR_CNT, 2);
    chk("abort_busy", BUSY, 0);

    // ABORT together with START in IDLE does nothing.
    @(negedge CLK);
    ABORT = 1'b1; START = 1'b1; NUM_VEC = 7'd5;
    @(negedge CLK);
    ABORT = 1'b0; START = 1'b0;
    chk("idle_abort_busy", BUSY, 0);
    chk("idle_abort_err_hold", ERR_CNT, 2);

    // MODE=10: LFSR when enabled, binary otherwise.
    run_sweep(2, 63, 0, 0, 0);
`ifdef OA222_STIM_LFSR_EN
    chk("m10_vec0", seen_stim[0], 6'h01);
    chk("m10_vec5", seen_stim[5], 6'h21);
`else
    chk("m10_vec0", seen_stim[0], 6'h00);
    chk("m10_vec5", seen_stim[5], 6'h05);
`endif
    chk("m10_done_cycle", done_k, 252);

    // Mode 11 behaves as binary; NUM_VEC above 64 clamps to 64.
    run_sweep(3, 100, 0, 0, 0);
    chk("clamp_done_cycle", done_k, 256);
    chk("clamp_tog_cnt", TOG_CNT, 17);

    // Asynchronous reset in SETTLE of vector 1.
    @(negedge CLK);
    dut_kind = 1; MODE = 2'b00; NUM_VEC = 7'd64; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("prerst_busy", BUSY, 1);
    chk("prerst_err_cnt", ERR_CNT, 1);
    RSTB = 1'b0;
    #1;
    chk("arst_stim", STIM, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_err_cnt", ERR_CNT, 0);
    chk("arst_err_vec", ERR_VEC, 0);
    chk("arst_err_vld", ERR_VLD, 0);
    @(negedge CLK);
    RSTB = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_stim", STIM, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
